dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data memory between the CPU load/store path (port 0) and the debug/program loader (port 1). At most one memory access completes per clock: reads are combinational through the memory, and writes commit at the clock edge. Port 0 has fixed priority. A starvation counter forces a port-1 grant after a bounded wait. Out-of-range addresses are completed with an error flag and never reach the memory's write enable.

---
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU load/store
// path (port 0, fixed priority) and the debug/program loader (port 1).
// A starvation counter forces a port-1 grant after MAX_WAIT consecutive
// losses. Out-of-range word addresses complete with an error flag and never
// assert the memory write enable.
module dmem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 100,
  parameter int MAX_WAIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p0_req,
  input  logic             p0_we,
  input  logic [31:0]      p0_addr,
  input  logic [WIDTH-1:0] p0_wdata,
  input  logic             p1_req,
  input  logic             p1_we,
  input  logic [31:0]      p1_addr,
  input  logic [WIDTH-1:0] p1_wdata,
  output logic             p0_gnt,
  output logic             p1_gnt,
  output logic             p0_done,
  output logic             p1_done,
  output logic             p0_err,
  output logic             p1_err,
  output logic [WIDTH-1:0] p0_rdata,
  output logic [WIDTH-1:0] p1_rdata,
  output logic [31:0]      mem_A,
  output logic [WIDTH-1:0] mem_WriteData,
  output logic             mem_WE,
  input  logic [WIDTH-1:0] mem_ReadData
);

  // Range limit as a full 32-bit unsigned value so huge addresses compare correctly.
  localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH);
  localparam logic [7:0]  WAIT_LIMIT  = 8'(MAX_WAIT);

  // Number of consecutive port-0 grants port 1 has lost while requesting.
  logic [7:0] cnt;
  logic       p0_oor;
  logic       p1_oor;

  assign p0_oor = (p0_addr >= DEPTH_LIMIT);
  assign p1_oor = (p1_addr >= DEPTH_LIMIT);

  // Grant selection: forced port-1 turn first, then port-0 priority, then port 1.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (rst) begin
      p0_gnt = 1'b0;
      p1_gnt = 1'b0;
    end else if (p1_req && (cnt == WAIT_LIMIT)) begin
      p1_gnt = 1'b1;
    end else if (p0_req) begin
      p0_gnt = 1'b1;
    end else if (p1_req) begin
      p1_gnt = 1'b1;
    end else begin
      p0_gnt = 1'b0;
      p1_gnt = 1'b0;
    end
  end

  // Memory port mux: winner drives the bus; write enable is masked by the range check.
  always_comb begin
    mem_A         = 32'h0000_0000;
    mem_WriteData = {WIDTH{1'b0}};
    mem_WE        = 1'b0;
    if (p0_gnt) begin
      mem_A         = p0_addr;
      mem_WriteData = p0_wdata;
      mem_WE        = p0_we & ~p0_oor;
    end else if (p1_gnt) begin
      mem_A         = p1_addr;
      mem_WriteData = p1_wdata;
      mem_WE        = p1_we & ~p1_oor;
    end else begin
      mem_A         = 32'h0000_0000;
      mem_WriteData = {WIDTH{1'b0}};
      mem_WE        = 1'b0;
    end
  end

  // Starvation counter: counts port-1 losses, saturates, clears on service or withdrawal.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (p1_gnt || !p1_req) begin
      cnt <= 8'd0;
    end else if (p0_gnt && (cnt < WAIT_LIMIT)) begin
      cnt <= cnt + 8'd1;
    end else begin
      cnt <= cnt;
    end
  end

  // Port-0 completion: one-cycle done/err pulse; read data captured only on good reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_done  <= 1'b0;
      p0_err   <= 1'b0;
      p0_rdata <= {WIDTH{1'b0}};
    end else begin
      p0_done <= p0_gnt;
      p0_err  <= p0_gnt & p0_oor;
      if (p0_gnt && !p0_we && !p0_oor) begin
        p0_rdata <= mem_ReadData;
      end else begin
        p0_rdata <= p0_rdata;
      end
    end
  end

  // Port-1 completion: one-cycle done/err pulse; read data captured only on good reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_done  <= 1'b0;
      p1_err   <= 1'b0;
      p1_rdata <= {WIDTH{1'b0}};
    end else begin
      p1_done <= p1_gnt;
      p1_err  <= p1_gnt & p1_oor;
      if (p1_gnt && !p1_we && !p1_oor) begin
        p1_rdata <= mem_ReadData;
      end else begin
        p1_rdata <= p1_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run, all checked against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 100;
  localparam int MAX_WAIT = 3;

  logic clk = 1'b0;
  logic rst;
  logic req [2];
  logic we [2];
  logic [31:0] addr [2];
  logic [WIDTH-1:0] wdata [2];

  logic p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err, mem_WE;
  logic [WIDTH-1:0] p0_rdata, p1_rdata, mem_WriteData, mem_ReadData;
  logic [31:0] mem_A;

  // Memory model behind the arbiter: combinational read, write at the edge.
  logic [WIDTH-1:0] mem [DEPTH] = '{default: 32'h0};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [WIDTH-1:0] ref_mem [DEPTH] = '{default: 32'h0};
  int ref_wait;
  logic exp_gnt [2];
  logic [31:0] exp_a;
  logic [WIDTH-1:0] exp_wd;
  logic exp_we;
  logic exp_done [2];
  logic exp_err [2];
  logic [WIDTH-1:0] exp_rd [2];

  // Observed DUT values for the current cycle
  logic obs_gnt [2];
  logic [31:0] obs_a;
  logic [WIDTH-1:0] obs_wd;
  logic obs_we;
  logic obs_done [2];
  logic obs_err [2];
  logic [WIDTH-1:0] obs_rd [2];

  dmem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_done(p0_done), .p1_done(p1_done),
    .p0_err(p0_err), .p1_err(p1_err), .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_A(mem_A), .mem_WriteData(mem_WriteData), .mem_WE(mem_WE),
    .mem_ReadData(mem_ReadData)
  );

  always #5 clk = ~clk;

  // Memory write port
  always @(posedge clk) begin
    if (mem_WE && (mem_A < 32'd100)) mem[mem_A[6:0]] <= mem_WriteData;
  end

  // Memory read port
  always_comb begin
    mem_ReadData = 32'h0;
    if (mem_A < 32'd100) mem_ReadData = mem[mem_A[6:0]];
  end

  function automatic logic out_of_range(input logic [31:0] a);
    return a >= 32'd100;
  endfunction

  // One clock cycle: predict the winner and bus, sample, take the edge, update the model.
  task automatic cycle();
    #1;
    exp_gnt[0] = 1'b0;
    exp_gnt[1] = 1'b0;
    if (!rst) begin
      if (req[1] && ref_wait >= MAX_WAIT) exp_gnt[1] = 1'b1;
      else if (req[0]) exp_gnt[0] = 1'b1;
      else if (req[1]) exp_gnt[1] = 1'b1;
    end
    exp_a = 32'h0; exp_wd = 32'h0; exp_we = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (exp_gnt[p]) begin
        exp_a = addr[p]; exp_wd = wdata[p]; exp_we = we[p] && !out_of_range(addr[p]);
      end
    end
    obs_gnt[0] = p0_gnt; obs_gnt[1] = p1_gnt;
    obs_a = mem_A; obs_wd = mem_WriteData; obs_we = mem_WE;
    @(posedge clk);
    if (rst) begin
      ref_wait = 0;
      for (int p = 0; p < 2; p++) begin
        exp_done[p] = 1'b0; exp_err[p] = 1'b0; exp_rd[p] = 32'h0;
      end
    end else begin
      if (exp_gnt[1] || !req[1]) ref_wait = 0;
      else if (exp_gnt[0] && ref_wait < MAX_WAIT) ref_wait = ref_wait + 1;
      for (int p = 0; p < 2; p++) begin
        exp_done[p] = exp_gnt[p];
        exp_err[p]  = exp_gnt[p] && out_of_range(addr[p]);
        if (exp_gnt[p] && !out_of_range(addr[p])) begin
          if (we[p]) ref_mem[addr[p][6:0]] = wdata[p];
          else exp_rd[p] = ref_mem[addr[p][6:0]];
        end
      end
    end
    #1;
    obs_done[0] = p0_done; obs_done[1] = p1_done;
    obs_err[0] = p0_err; obs_err[1] = p1_err;
    obs_rd[0] = p0_rdata; obs_rd[1] = p1_rdata;
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [31:0] a, input logic [WIDTH-1:0] d);
    req[p] = r; we[p] = w; addr[p] = a; wdata[p] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_port(0, 1'b1, 1'b1, 32'd3, 32'h1111_1111);
    set_port(1, 1'b1, 1'b1, 32'd4, 32'h2222_2222);
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++; if (obs_gnt[0] !== 1'b0 || obs_gnt[1] !== 1'b0) begin n_fail++;
        $display("FAIL reset_gnt cyc %0d got %b%b want 00", i, obs_gnt[0], obs_gnt[1]); end
      n_checks++; if (obs_we !== 1'b0) begin n_fail++;
        $display("FAIL reset_we cyc %0d got %b want 0", i, obs_we); end
    end
    for (int p = 0; p < 2; p++) begin
      n_checks++; if (obs_done[p] !== 1'b0 || obs_err[p] !== 1'b0 || obs_rd[p] !== 32'h0) begin n_fail++;
        $display("FAIL reset_out p%0d got done=%b err=%b rdata=%h want 0/0/0", p, obs_done[p], obs_err[p], obs_rd[p]); end
    end
    n_checks++; if (dut.cnt !== 8'd0) begin n_fail++;
      $display("FAIL reset_cnt got %0d want 0", dut.cnt); end
    rst = 1'b0;
    set_port(0, 1'b0, 1'b0, 32'd0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'h0);
  endtask

  task automatic test_single_port();
    set_port(1, 1'b0, 1'b0, 32'd0, 32'h0);
    set_port(0, 1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF);
    cycle();
    n_checks++; if (obs_gnt[0] !== 1'b1 || obs_we !== 1'b1 || obs_a !== 32'd5) begin n_fail++;
      $display("FAIL single_wr_bus got gnt=%b we=%b A=%0d want 1/1/5", obs_gnt[0], obs_we, obs_a); end
    n_checks++; if (obs_done[0] !== 1'b1 || obs_err[0] !== 1'b0) begin n_fail++;
      $display("FAIL single_wr_done got done=%b err=%b want 1/0", obs_done[0], obs_err[0]); end
    set_port(0, 1'b1, 1'b0, 32'd5, 32'h0);
    cycle();
    n_checks++; if (obs_done[0] !== 1'b1 || obs_rd[0] !== 32'hDEAD_BEEF) begin n_fail++;
      $display("FAIL single_rd got done=%b rdata=%h want 1/deadbeef", obs_done[0], obs_rd[0]); end
    n_checks++; if (obs_done[1] !== 1'b0 || obs_rd[1] !== exp_rd[1]) begin n_fail++;
      $display("FAIL single_p1_quiet got done=%b rdata=%h want 0/%h", obs_done[1], obs_rd[1], exp_rd[1]); end
    set_port(0, 1'b0, 1'b0, 32'd0, 32'h0);
    cycle();
  endtask

  task automatic test_starvation();
    logic [7:0] pat;
    pat = 8'b1000_1000;  // bit i set: port 1 wins cycle i
    set_port(0, 1'b1, 1'b0, 32'd10, 32'h0);
    set_port(1, 1'b1, 1'b0, 32'd20, 32'h0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      n_checks++; if (obs_gnt[1] !== pat[i] || obs_gnt[0] !== !pat[i]) begin n_fail++;
        $display("FAIL starve_gnt cyc %0d got p0=%b p1=%b want p1=%b", i, obs_gnt[0], obs_gnt[1], pat[i]); end
      n_checks++; if (obs_done[1] !== pat[i] || obs_done[0] !== !pat[i]) begin n_fail++;
        $display("FAIL starve_done cyc %0d got p0=%b p1=%b want p1=%b", i, obs_done[0], obs_done[1], pat[i]); end
      n_checks++; if (obs_rd[0] !== exp_rd[0] || obs_rd[1] !== exp_rd[1]) begin n_fail++;
        $display("FAIL starve_rdata cyc %0d got %h/%h want %h/%h", i, obs_rd[0], obs_rd[1], exp_rd[0], exp_rd[1]); end
    end
    set_port(0, 1'b0, 1'b0, 32'd0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'h0);
    cycle();
  endtask

  task automatic test_p1_drop();
    logic [6:0] p1_on;
    logic [6:0] p1_win;
    p1_on  = 7'b111_1011;  // bit i: p1_req in cycle i
    p1_win = 7'b100_0000;
    set_port(0, 1'b1, 1'b0, 32'd30, 32'h0);
    for (int i = 0; i < 7; i++) begin
      set_port(1, p1_on[i], 1'b0, 32'd31, 32'h0);
      cycle();
      n_checks++; if (obs_gnt[1] !== p1_win[i]) begin n_fail++;
        $display("FAIL drop_gnt cyc %0d got %b want %b", i, obs_gnt[1], p1_win[i]); end
      if (i == 2) begin
        n_checks++; if (dut.cnt !== 8'd0) begin n_fail++;
          $display("FAIL drop_cnt got %0d want 0", dut.cnt); end
      end
    end
    set_port(0, 1'b0, 1'b0, 32'd0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'h0);
    cycle();
  endtask

  task automatic test_out_of_range();
    set_port(0, 1'b0, 1'b0, 32'd0, 32'h0);
    set_port(1, 1'b1, 1'b1, 32'd100, 32'h0000_1234);
    cycle();
    n_checks++; if (obs_gnt[1] !== 1'b1 || obs_we !== 1'b0) begin n_fail++;
      $display("FAIL oor_wr_bus got gnt=%b we=%b want 1/0", obs_gnt[1], obs_we); end
    n_checks++; if (obs_done[1] !== 1'b1 || obs_err[1] !== 1'b1) begin n_fail++;
      $display("FAIL oor_wr_done got done=%b err=%b want 1/1", obs_done[1], obs_err[1]); end
    set_port(1, 1'b1, 1'b1, 32'd99, 32'h0000_A5A5);
    cycle();
    n_checks++; if (obs_we !== 1'b1 || obs_err[1] !== 1'b0) begin n_fail++;
      $display("FAIL edge99_wr got we=%b err=%b want 1/0", obs_we, obs_err[1]); end
    set_port(1, 1'b1, 1'b0, 32'd99, 32'h0);
    cycle();
    n_checks++; if (obs_rd[1] !== 32'h0000_A5A5 || obs_err[1] !== 1'b0) begin n_fail++;
      $display("FAIL edge99_rd got rdata=%h err=%b want 0000a5a5/0", obs_rd[1], obs_err[1]); end
    set_port(1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);
    cycle();
    n_checks++; if (obs_done[1] !== 1'b1 || obs_err[1] !== 1'b1 || obs_rd[1] !== 32'h0000_A5A5) begin n_fail++;
      $display("FAIL oor_rd got done=%b err=%b rdata=%h want 1/1/0000a5a5", obs_done[1], obs_err[1], obs_rd[1]); end
    set_port(1, 1'b0, 1'b0, 32'd0, 32'h0);
    cycle();
  endtask

  task automatic test_idle();
    set_port(0, 1'b0, 1'b1, 32'd7, 32'hFFFF_0000);
    set_port(1, 1'b0, 1'b1, 32'd8, 32'h0000_FFFF);
    cycle();
    n_checks++; if (obs_a !== 32'h0 || obs_wd !== 32'h0 || obs_we !== 1'b0) begin n_fail++;
      $display("FAIL idle_bus got A=%h WD=%h WE=%b want 0/0/0", obs_a, obs_wd, obs_we); end
    n_checks++; if (obs_done[0] !== 1'b0 || obs_done[1] !== 1'b0) begin n_fail++;
      $display("FAIL idle_done got %b%b want 00", obs_done[0], obs_done[1]); end
  endtask

  task automatic test_back_to_back();
    set_port(1, 1'b0, 1'b0, 32'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      set_port(0, 1'b1, 1'b1, 32'd40 + 32'(i), 32'h1000 + 32'(i));
      cycle();
      n_checks++; if (obs_done[0] !== 1'b1) begin n_fail++;
        $display("FAIL b2b_wr_done cyc %0d got %b want 1", i, obs_done[0]); end
    end
    for (int i = 0; i < 3; i++) begin
      set_port(0, 1'b1, 1'b0, 32'd40 + 32'(i), 32'h0);
      cycle();
      n_checks++; if (obs_done[0] !== 1'b1 || obs_rd[0] !== 32'h1000 + 32'(i)) begin n_fail++;
        $display("FAIL b2b_rd cyc %0d got done=%b rdata=%h want 1/%h", i, obs_done[0], obs_rd[0], 32'h1000 + 32'(i)); end
    end
    set_port(0, 1'b0, 1'b0, 32'd0, 32'h0);
    cycle();
  endtask

  task automatic test_random(input int n);
    logic [31:0] a;
    int r;
    for (int i = 0; i < n; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req[p] || exp_gnt[p]) begin
          r = int'($urandom_range(0, 9));
          if (r == 0) a = 32'hFFFF_FFFF;
          else if (r == 1) a = $urandom_range(100, 120);
          else if (r == 2) a = $urandom_range(95, 99);
          else a = $urandom_range(0, 99);
          set_port(p, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, a, $urandom);
        end
      end
      rst = ($urandom_range(0, 39) == 0);
      cycle();
      n_checks++; if (obs_gnt[0] !== exp_gnt[0] || obs_gnt[1] !== exp_gnt[1]) begin n_fail++;
        $display("FAIL rand_gnt cyc %0d got %b%b want %b%b", i, obs_gnt[0], obs_gnt[1], exp_gnt[0], exp_gnt[1]); end
      n_checks++; if (obs_a !== exp_a || obs_wd !== exp_wd || obs_we !== exp_we) begin n_fail++;
        $display("FAIL rand_bus cyc %0d got %h/%h/%b want %h/%h/%b", i, obs_a, obs_wd, obs_we, exp_a, exp_wd, exp_we); end
      for (int p = 0; p < 2; p++) begin
        n_checks++; if (obs_done[p] !== exp_done[p] || obs_err[p] !== exp_err[p] || obs_rd[p] !== exp_rd[p]) begin n_fail++;
          $display("FAIL rand_out p%0d cyc %0d got %b/%b/%h want %b/%b/%h", p, i,
                   obs_done[p], obs_err[p], obs_rd[p], exp_done[p], exp_err[p], exp_rd[p]); end
      end
    end
    rst = 1'b0;
    set_port(0, 1'b0, 1'b0, 32'd0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'h0);
    cycle();
  endtask

  initial begin
    ref_wait = 0;
    for (int p = 0; p < 2; p++) begin
      exp_gnt[p] = 1'b0; exp_done[p] = 1'b0; exp_err[p] = 1'b0; exp_rd[p] = 32'h0;
    end
    rst = 1'b1;
    set_port(0, 1'b0, 1'b0, 32'd0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'h0);
    @(posedge clk);
    #1;
    test_reset();
    test_single_port();
    test_starvation();
    test_p1_drop();
    test_out_of_range();
    test_idle();
    test_back_to_back();
    test_random(400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
